switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Input conditioner for the board's slide switches and push buttons. It synchronises each raw pin into the `clock` domain, rejects mechanical bounce, and presents a stable switch vector plus single-cycle rise/fall strobes. The board-level logic that drives the LEDs consumes these outputs in place of the raw pins. All bits are handled independently and share one sample-tick prescaler.

## Interface
- `WIDTH`, 16: number of switch bits.
- `SYNC_STAGES`, 2: synchroniser flops per bit; must be ≥ 2.
- `TICK_CYCLES`, 100000: clock cycles per sample tick (1 ms at 100 MHz); must be ≥ 2.
- `STABLE_TICKS`, 10: consecutive disagreeing ticks needed to accept a new level; must be ≥ 1.

Ports:
- `clock`  in  1  sole clock; all flops on its rising edge.
- `clear_n`  in  1  reset, asynchronous assert, active-low; synchronous deassert is the board's responsibility.
- `switches_raw`  in  WIDTH  raw pins, asynchronous to `clock`.
- `switches_clean`  out  WIDTH  debounced level, registered.
- `rise`  out  WIDTH  one-cycle strobe per bit when its clean level goes 0→1, registered.
- `fall`  out  WIDTH  one-cycle strobe per bit when its clean level goes 1→0, registered.
- `any_change`  out  1  OR-reduction of `rise | fall`, combinational from the registered strobes.
- `tick`  out  1  prescaler strobe, exported for debug and the bench.

## Operation
- **Synchroniser:** a `SYNC_STAGES`-deep shift chain per bit, reset to 0. Its last stage is `s[i]`.
- **Prescaler:** counter `pc` counts 0..TICK_CYCLES-1 and wraps to 0.
  - `tick` = 1 exactly in cycles where `pc == TICK_CYCLES-1`.
  - Width is `clog2(TICK_CYCLES)`.
- **Per-bit counter** `cnt[i]`, width `clog2(STABLE_TICKS+1)`. Evaluated every cycle, in priority order:
  1. If `s[i] == switches_clean[i]`: `cnt[i] <= 0`. This applies on every cycle, not only on ticks.
  2. Else if `tick` and `cnt[i] == STABLE_TICKS-1`: `switches_clean[i] <= s[i]`, `cnt[i] <= 0`, and pulse `rise[i]` (if `s[i]`=1) or `fall[i]` (if `s[i]`=0) in the next cycle, coincident with the clean update.
  3. Else if `tick`: `cnt[i] <= cnt[i] + 1`.
  4. Else: hold.
- `rise` and `fall` default to 0 every cycle and never stay high for two consecutive cycles. For a given bit, `rise[i]` and `fall[i]` are never high together.
- **Bounce:** any return of `s[i]` to the clean level, even for one cycle, zeroes `cnt[i]`. The count restarts from scratch.
- **Simultaneous events:** `s[i]` reverting in the same cycle as the accepting tick means priority 1 wins and there is no flip. Multiple bits may flip in the same cycle.
- **Reset:** asserting `clear_n` = 0 immediately forces the following to 0:
  - the synchroniser chains, `pc`, every `cnt`;
  - `switches_clean`, `rise`, `fall`, `any_change`, `tick`.
- **After reset:** a switch physically on is accepted through the full debounce and produces a `rise` strobe. This is intended.

## Timing
- **Reset values:** all outputs are 0.
- **Synchroniser latency:** `SYNC_STAGES` cycles from a raw edge to `s[i]`.
- **Accept latency:** from `s[i]` diverging to the `switches_clean[i]` update is between (STABLE_TICKS-1)·TICK_CYCLES+1 and STABLE_TICKS·TICK_CYCLES cycles, depending on prescaler phase.
- **First tick:** occurs TICK_CYCLES cycles after `clear_n` deasserts.
- **Glitch rejection:** a pulse shorter than (STABLE_TICKS-1)·TICK_CYCLES+1 cycles after synchronisation is never accepted.
- **Throughput:** one accepted transition per bit per STABLE_TICKS ticks at most.
- **No backpressure:** strobes are fire-and-forget.

## Test plan
Bench parameters: `WIDTH`=16, `SYNC_STAGES`=2, `TICK_CYCLES`=4, `STABLE_TICKS`=3.

- **Reset hold:** hold `clear_n`=0 while toggling `switches_raw` randomly for 50 cycles, then release with raw=0. Required: all outputs stay 0; `tick` first asserts 4 cycles after release.
- **Clean step:** after reset, set `switches_raw[0]`=1 and hold. Required:
  - `switches_clean[0]` rises between 11 and 14 cycles after the raw edge;
  - `rise[0]` and `any_change` are high for exactly one cycle, coincident with that rise;
  - no `fall` pulse.
- **Bounce rejection:** toggle `switches_raw[5]` every 5 cycles for 80 cycles, then hold it at 1. Required:
  - no change on `switches_clean[5]` and no strobes during the toggling;
  - after the hold, a single `rise[5]` within 14 cycles of the last edge.
- **Release:** with `switches_clean[3]`=1, drive raw[3]=0 and hold. Required: `fall[3]` for one cycle, `switches_clean[3]`=0, `rise`=0 throughout.
- **Multi-bit:** drive raw from 0x0000 to 0xA5A5 in one cycle. Required:
  - `switches_clean` becomes 0xA5A5 in a single cycle;
  - `rise`=0xA5A5 for exactly one cycle;
  - `fall`=0 throughout.
- **Reset mid-count:** set raw[7]=1 and, after 2 ticks of disagreement, pulse `clear_n` low for 1 cycle. Required:
  - outputs drop to 0 asynchronously, without waiting for a clock edge;
  - after release, `rise[7]` appears only after a full 11–14 cycle debounce, never earlier.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// Switch conditioner signal bundle.
//   switches_raw   : raw pins into the conditioner (async to clock)
//   switches_clean : debounced level
//   rise / fall    : one-cycle per-bit edge strobes
//   any_change     : OR of all strobes
//   tick           : prescaler strobe (debug / bench visibility)
// master = the side that drives the pins, slave = the conditioner itself.
interface switch_debouncer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] switches_raw;
    logic [WIDTH-1:0] switches_clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;
    logic             tick;

    modport master (
        output switches_raw,
        input  switches_clean, rise, fall, any_change, tick
    );

    modport slave (
        input  switches_raw,
        output switches_clean, rise, fall, any_change, tick
    );
endinterface

// File: rtl/switch_debouncer.sv
// Debounces WIDTH switch/button pins with a shared sample-tick prescaler.
// Each bit is synchronised through SYNC_STAGES flops, then must disagree
// with its clean level for STABLE_TICKS consecutive ticks before the new
// level is accepted. Accepting a level fires a one-cycle rise/fall strobe
// that lines up with the clean-level update.
// Ports:
//   clock   : sole clock, rising edge
//   clear_n : async active-low reset (deassert synchronised by the board)
//   sw      : slave side of switch_debouncer_if (raw in, clean/strobes out)
module switch_debouncer #(
    parameter int WIDTH        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_CYCLES  = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic              clock,
    input  logic              clear_n,
    switch_debouncer_if.slave sw
);
    localparam int PC_W  = $clog2(TICK_CYCLES);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [PC_W-1:0]                   pc_q, pc_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  clean_q, clean_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  s;
    logic                              tick;

    assign s    = sync_q[SYNC_STAGES-1];
    // pc resets to 0 and TICK_CYCLES >= 2, so tick is low during reset.
    assign tick = (pc_q == PC_W'(TICK_CYCLES - 1));

    always_comb begin
        sync_d[0] = sw.switches_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        pc_d = tick ? '0 : pc_q + PC_W'(1);
    end

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == clean_q[i]) begin
                // Agreement on any cycle (tick or not) restarts the count,
                // so a single-cycle bounce back discards all progress.
                cnt_d[i] = '0;
            end else if (tick && cnt_q[i] == CNT_W'(STABLE_TICKS - 1)) begin
                clean_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_q  <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw.switches_clean = clean_q;
    assign sw.rise           = rise_q;
    assign sw.fall           = fall_q;
    assign sw.any_change     = |(rise_q | fall_q);
    assign sw.tick           = tick;
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with WIDTH=16, SYNC_STAGES=2, TICK_CYCLES=4,
// STABLE_TICKS=3. Stimulus pushes the expected strobe event (rise/fall
// vectors, clean level and the cycle window it must land in) into a queue;
// a negedge monitor pops one entry whenever the DUT shows any strobe.
module tb_switch_debouncer;
    localparam int W  = 16;
    localparam int SS = 2;
    localparam int TC = 4;
    localparam int ST = 3;

    logic clock   = 1'b0;
    logic clear_n = 1'b0;
    int   cyc     = 0;

    switch_debouncer_if #(.WIDTH(W)) sw ();

    switch_debouncer #(
        .WIDTH(W), .SYNC_STAGES(SS), .TICK_CYCLES(TC), .STABLE_TICKS(ST)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .sw      (sw)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] clean;
        int           lo;
        int           hi;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp     = 0;
    int           n_bad     = 0;
    logic [W-1:0] exp_clean = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe cycle must match the oldest pending event.
    always @(negedge clock) begin
        exp_t it;
        if (sw.any_change || (|sw.rise) || (|sw.fall)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: rise=%h fall=%h any=%b at cycle %0d, expected no strobe",
                         sw.rise, sw.fall, sw.any_change, cyc);
            end else begin
                it = exp_q.pop_front();
                check({it.name, "_rise"},  64'(sw.rise),           64'(it.rise));
                check({it.name, "_fall"},  64'(sw.fall),           64'(it.fall));
                check({it.name, "_clean"}, 64'(sw.switches_clean), 64'(it.clean));
                check({it.name, "_any"},   64'(sw.any_change),     64'(1));
                n_cmp++;
                if (cyc < it.lo || cyc > it.hi) begin
                    n_bad++;
                    $display("FAIL %s_latency: strobe at cycle %0d, expected within %0d..%0d",
                             it.name, cyc, it.lo, it.hi);
                end
            end
        end
    end

    // Drive a raw vector just after a rising edge and queue the event it must
    // cause: sync (2) + worst/best debounce gives 11..14 cycles after the edge.
    task automatic push_edge(input string name, input logic [W-1:0] raw,
                             input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t it;
        @(posedge clock);
        #1;
        sw.switches_raw = raw;
        exp_clean = (exp_clean | r) & ~f;
        it.rise  = r;
        it.fall  = f;
        it.clean = exp_clean;
        it.lo    = cyc + 11;
        it.hi    = cyc + 14;
        it.name  = name;
        exp_q.push_back(it);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clock);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d events pending after 40 cycles, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        // Idle a few cycles so a repeated strobe shows up as unexpected.
        repeat (6) @(posedge clock);
        @(negedge clock);
        check({name, "_settled_clean"}, 64'(sw.switches_clean), 64'(exp_clean));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rel;
        int e;
        int nt;
        int k;

        // Reset hold with random pin activity: every output must stay 0.
        sw.switches_raw = '0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            sw.switches_raw = W'($urandom);
            @(negedge clock);
            check("reset_hold",
                  64'({sw.switches_clean, sw.rise, sw.fall, sw.any_change, sw.tick}), 64'(0));
        end

        // Release with raw=0; pc counts 0,1,2,3 so tick is seen in the 4th cycle.
        @(posedge clock);
        #1;
        sw.switches_raw = '0;
        clear_n = 1'b1;
        rel = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("first_tick_c%0d", cyc - rel), 64'(sw.tick), 64'(i == 3));
        end

        // Clean step on bit 0.
        push_edge("step", 16'h0001, 16'h0001, 16'h0000);
        wait_done("step");

        // Bounce on bit 5: 5-cycle levels never survive 3 ticks.
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            sw.switches_raw[5] = ~sw.switches_raw[5];
            repeat (4) @(posedge clock);
        end
        @(negedge clock);
        check("bounce_hold_clean", 64'(sw.switches_clean), 64'(16'h0001));
        push_edge("bounce", 16'h0021, 16'h0020, 16'h0000);
        wait_done("bounce");

        // Release on bit 3.
        push_edge("rel3_on",  16'h0029, 16'h0008, 16'h0000);
        wait_done("rel3_on");
        push_edge("rel3_off", 16'h0021, 16'h0000, 16'h0008);
        wait_done("rel3_off");

        // Multi-bit: back to zero (two falls together), then 0xA5A5 in one step.
        push_edge("to_zero", 16'h0000, 16'h0000, 16'h0021);
        wait_done("to_zero");
        push_edge("multi", 16'hA5A5, 16'hA5A5, 16'h0000);
        wait_done("multi");

        // Reset mid-count: bit 7 first to 0, then raise it and reset after 2 ticks.
        push_edge("bit7_off", 16'hA525, 16'h0000, 16'h0080);
        wait_done("bit7_off");
        @(posedge clock);
        #1;
        sw.switches_raw = 16'hA5A5;
        e  = cyc;
        nt = 0;
        k  = 0;
        while (nt < 2 && k < 30) begin
            @(negedge clock);
            if (cyc >= e + 2 && sw.tick) nt++;
            k++;
        end
        check("mid_ticks_seen", 64'(nt), 64'(2));
        @(posedge clock);
        check("pre_clear_clean", 64'(sw.switches_clean), 64'(16'hA525));
        #2;
        clear_n = 1'b0;
        #1;
        // Still 3 ns before the next clock edge: the drop must be asynchronous.
        check("async_clear",
              64'({sw.switches_clean, sw.rise, sw.fall, sw.any_change, sw.tick}), 64'(0));
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        rel = cyc;
        begin
            exp_t it;
            exp_clean = 16'hA5A5;
            it.rise  = 16'hA5A5;
            it.fall  = 16'h0000;
            it.clean = 16'hA5A5;
            it.lo    = rel + 11;
            it.hi    = rel + 14;
            it.name  = "post_clear";
            exp_q.push_back(it);
        end
        wait_done("post_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
